// File: rtl/cover_pkg.sv
// Shared definitions for cover collectors: global cover index type, default
// cover-space size and a popcount helper.
package cover_pkg;

  localparam int unsigned COVER_IDX_W         = 64;
  localparam int unsigned COVER_TOTAL_DEFAULT = 8744;
  localparam int unsigned POPCOUNT_MAX_W      = 1024;

  typedef logic [COVER_IDX_W-1:0] cover_idx_t;

  // Callers zero-extend narrower vectors to POPCOUNT_MAX_W.
  function automatic int unsigned popcount(input logic [POPCOUNT_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POPCOUNT_MAX_W; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/cover_lsb_enc.sv
// Lowest-set-bit encoder: reports whether any bit is set, the index of the
// lowest set bit and that bit as a one-hot mask.
module cover_lsb_enc #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_vec,
  output logic             any,
  output logic [IDX_W-1:0] index,
  output logic [WIDTH-1:0] onehot
);

  always_comb begin
    any    = |in_vec;
    onehot = in_vec & (~in_vec + WIDTH'(1));
    index  = '0;
    // Scan downward so the lowest set bit is the last assignment.
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (in_vec[i-1]) index = IDX_W'(i - 1);
    end
  end

endmodule

// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: sticky first-hit bitmap, deduplicated emission of
// newly covered points on a valid/ready stream, and a live covered count.
module cover_toggle_collector
  import cover_pkg::*;
#(
  parameter int unsigned WIDTH       = 20,
  parameter int unsigned COVER_INDEX = 0,
  parameter int unsigned COVER_TOTAL = COVER_TOTAL_DEFAULT,
  parameter int unsigned CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic                   gbl_clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       valid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COVER_IDX_W-1:0] out_index,
  output logic [CNT_W-1:0]       covered_count,
  output logic                   all_covered,
  output logic                   backlog
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < 1 || WIDTH > POPCOUNT_MAX_W) begin : g_bad_width
    $error("cover_toggle_collector: WIDTH must be 1..1024");
  end
  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_range
    $error("cover_toggle_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
  end

  logic [WIDTH-1:0] seen_q, seen_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             out_valid_q, out_valid_d;
  cover_idx_t       out_index_q, out_index_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             all_q, all_d;

  logic [WIDTH-1:0] hit, cand, enc_mask;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any, slot_free;

  always_comb begin
    hit       = (en ? valid : '0) & (clear ? '1 : ~seen_q);
    cand      = (clear ? '0 : pend_q) | hit;
    slot_free = !out_valid_q || out_ready;
  end

  cover_lsb_enc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_lsb_enc (
    .in_vec (cand),
    .any    (enc_any),
    .index  (enc_idx),
    .onehot (enc_mask)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    pend_d      = cand;
    if (slot_free) begin
      if (enc_any) begin
        out_valid_d = 1'b1;
        out_index_d = cover_idx_t'(COVER_INDEX) + cover_idx_t'(enc_idx);
        pend_d      = cand & ~enc_mask;
      end else begin
        out_valid_d = 1'b0;
        pend_d      = '0;
      end
    end
    seen_d  = (clear ? '0 : seen_q) | hit;
    count_d = CNT_W'(popcount(POPCOUNT_MAX_W'(seen_d)));
    all_d   = &seen_d;
  end

  always_ff @(posedge gbl_clk) begin
    if (!reset) begin
      seen_q      <= '0;
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      count_q     <= '0;
      all_q       <= 1'b0;
    end else begin
      seen_q      <= seen_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      count_q     <= count_d;
      all_q       <= all_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_index     = out_index_q;
  assign covered_count = count_q;
  assign all_covered   = all_q;
  assign backlog       = |pend_q;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Self-checking bench for cover_toggle_collector: directed scenarios plus
// randomized traffic, every cycle compared against a set-based reference model.
module tb_cover_toggle_collector;

  localparam int unsigned W    = 20;
  localparam int unsigned BASE = 100;
  localparam int unsigned CW   = $clog2(W + 1);

  logic          gbl_clk = 1'b0;
  logic          reset, en, clear, out_ready;
  logic [W-1:0]  valid;
  logic          out_valid, all_covered, backlog;
  logic [63:0]   out_index;
  logic [CW-1:0] covered_count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state: sets of covered / waiting point numbers.
  bit          m_seen[W];
  bit          m_pend[W];
  bit          m_ov;
  longint      m_oi;

  cover_toggle_collector #(
    .WIDTH       (W),
    .COVER_INDEX (BASE),
    .COVER_TOTAL (8744)
  ) dut (
    .gbl_clk       (gbl_clk),
    .reset         (reset),
    .en            (en),
    .clear         (clear),
    .valid         (valid),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_index     (out_index),
    .covered_count (covered_count),
    .all_covered   (all_covered),
    .backlog       (backlog)
  );

  always #5 gbl_clk = ~gbl_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit e, input bit clr,
                            input logic [W-1:0] v, input bit rdy);
    bit     newly[W];
    bit     waiting[W];
    int     lowest;
    if (!rst) begin
      foreach (m_seen[i]) begin m_seen[i] = 0; m_pend[i] = 0; end
      m_ov = 0;
      m_oi = 0;
      return;
    end
    lowest = -1;
    foreach (newly[i]) begin
      newly[i]   = e && v[i] && (clr || !m_seen[i]);
      waiting[i] = (!clr && m_pend[i]) || newly[i];
      if (waiting[i] && lowest < 0) lowest = i;
    end
    if (!m_ov || rdy) begin
      if (lowest >= 0) begin
        m_ov = 1;
        m_oi = BASE + lowest;
        waiting[lowest] = 0;
        m_pend = waiting;
      end else begin
        m_ov = 0;
        foreach (m_pend[i]) m_pend[i] = 0;
      end
    end else begin
      m_pend = waiting;
    end
    foreach (m_seen[i]) m_seen[i] = (!clr && m_seen[i]) || newly[i];
  endtask

  function automatic int model_count();
    int n = 0;
    foreach (m_seen[i]) n += m_seen[i];
    return n;
  endfunction

  function automatic bit model_backlog();
    foreach (m_pend[i]) if (m_pend[i]) return 1;
    return 0;
  endfunction

  task automatic cyc(input bit rst, input bit e, input bit clr,
                     input logic [W-1:0] v, input bit rdy);
    @(negedge gbl_clk);
    reset = rst; en = e; clear = clr; valid = v; out_ready = rdy;
    model_step(rst, e, clr, v, rdy);
    @(posedge gbl_clk);
    #1;
    check("out_valid", out_valid, m_ov);
    if (m_ov) check("out_index", out_index, m_oi);
    check("covered_count", covered_count, model_count());
    check("all_covered", all_covered, model_count() == W);
    check("backlog", backlog, model_backlog());
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; clear = 1'b0; valid = '0; out_ready = 1'b0;

    // Reset with all hits asserted.
    repeat (3) cyc(0, 1, 0, '1, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_index", out_index, 0);
    check("rst_count", covered_count, 0);
    cyc(1, 1, 0, '0, 1);
    check("post_rst_valid", out_valid, 0);

    // Two points, then a repeat that must be silent.
    cyc(1, 1, 0, 20'h00005, 1);
    check("first_idx", out_index, 100);
    cyc(1, 1, 0, '0, 1);
    check("second_idx", out_index, 102);
    check("count_two", covered_count, 2);
    cyc(1, 1, 0, 20'h00005, 1);
    check("repeat_silent", out_valid, 0);

    // Full burst under stall, then drain.
    cyc(0, 0, 0, '0, 0);
    cyc(1, 1, 0, 20'hFFFFF, 0);
    check("burst_all", all_covered, 1);
    repeat (4) cyc(1, 1, 0, '0, 0);
    check("burst_hold", out_index, 100);
    for (int k = 0; k < 19; k++) begin
      cyc(1, 1, 0, '0, 1);
      check("drain_idx", out_index, 101 + k);
    end
    check("drain_backlog", backlog, 0);

    // Clear together with a hit after full coverage.
    cyc(1, 1, 0, '0, 1);
    cyc(1, 1, 1, 20'h00008, 1);
    check("clear_count", covered_count, 1);
    check("clear_all", all_covered, 0);
    check("clear_idx", out_index, 103);
    cyc(1, 1, 0, '0, 1);
    check("clear_once", out_valid, 0);

    // Low-index hit overtakes older pending point.
    cyc(0, 0, 0, '0, 0);
    cyc(1, 1, 0, 20'h00420, 0);
    check("stall_idx", out_index, 105);
    cyc(1, 1, 0, 20'h00004, 0);
    cyc(1, 1, 0, '0, 1);
    check("overtake_idx", out_index, 102);
    cyc(1, 1, 0, '0, 1);
    check("after_overtake", out_index, 110);

    // en=0 leaves state untouched; reset mid-drain stops emission.
    cyc(1, 0, 0, 20'hFFFFF, 1);
    check("en_off_count", covered_count, 3);
    cyc(1, 1, 0, 20'hFFFFF, 1);
    cyc(1, 1, 0, '0, 1);
    cyc(0, 1, 0, '0, 1);
    check("mid_rst_valid", out_valid, 0);
    cyc(1, 1, 0, '0, 1);
    check("mid_rst_quiet", out_valid, 0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic [W-1:0] v;
      v = W'($urandom & $urandom & $urandom);
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 39) == 0), v, ($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule

// File: doc/cover_toggle_collector.md
# cover_toggle_collector

Parametrised toggle-coverage collector: samples a WIDTH-bit toggle-hit vector every gbl_clk cycle and records first hits in a sticky bitmap. Each newly covered point is emitted exactly once as an absolute cover index on a valid/ready stream. The block runs between the per-signal toggle detectors and the coverage sink (DPI shim, trace buffer or formal cover harness), replacing per-bit, per-cycle reporting with deduplicated, back-pressurable reporting plus a live covered-point count.

## Interface
- WIDTH, 20: number of toggle points handled by this instance (1..1024)
- COVER_INDEX, 0: absolute index of bit 0 in the global cover space
- COVER_TOTAL, 8744: size of global cover space; requires COVER_INDEX+WIDTH <= COVER_TOTAL (elaboration assertion)
- CNT_W, $clog2(WIDTH+1): derived, width of covered_count
- gbl_clk  in  1  clock
- reset  in  1  synchronous, active-low; clock gbl_clk
- en  in  1  sampling enable; valid ignored when 0
- clear  in  1  synchronous re-arm: forget all coverage
- valid  in  WIDTH  per-point hit strobe for this cycle
- out_valid  out  1  out_index holds a newly covered point
- out_ready  in  1  sink accepts out_index
- out_index  out  64  absolute cover index (COVER_INDEX + bit)
- covered_count  out  CNT_W  popcount of sticky bitmap
- all_covered  out  1  every point of this instance covered
- backlog  out  1  first hits still queued behind the output register

## Operation
- State: seen[WIDTH] (sticky), pend[WIDTH] (hit but not yet emitted), output register {out_valid, out_index}, covered_count.
- hit = (en ? valid : 0) & ~seen; with clear=1, hit = (en ? valid : 0) (bitmap treated as empty).
- cand = (clear ? 0 : pend) | hit.
- slot_free = !out_valid | out_ready.
- If slot_free and cand != 0: load out_index <= COVER_INDEX + lowest set bit of cand; out_valid <= 1; pend <= cand with that bit removed.
- If slot_free and cand == 0: out_valid <= 0; pend <= 0.
- If !slot_free: output register unchanged; pend <= cand.
- seen <= (clear ? 0 : seen) | hit; covered_count <= popcount of new seen; all_covered <= (new seen == all ones).
- backlog = (pend != 0), combinational from registered pend.
- Each point is emitted at most once between resets/clears; never dropped, because pend is a bitmap and cannot overflow.
- Repeated hits on a covered point: no effect on any state.
- clear does not cancel an out_valid already presented; it completes normally. A point already in the output register may therefore be emitted again after clear if re-hit.
- Reset (reset==0): seen=0, pend=0, out_valid=0, out_index=0, covered_count=0, all_covered=0, backlog=0; overrides clear, en and valid.

## Timing
- Latency: valid bit sampled at edge N -> out_valid/out_index visible after edge N (one cycle), provided the slot is free and no lower-indexed point is pending.
- Throughput: one index per cycle with out_ready held high.
- Ordering: among queued points, lowest bit index first; a newer low-index hit can overtake older high-index pending points.
- out_valid, once high, stays high with out_index stable until the cycle out_ready=1 (AXI-style; out_valid never depends on out_ready combinationally).
- covered_count/all_covered update on the same edge that sets seen; they count points hit, not points emitted.
- Worst-case drain: WIDTH simultaneous first hits emit over WIDTH consecutive cycles.

## Structure
- Shared package cover_pkg: COVER_IDX_W = 64 and cover_idx_t typedef; default COVER_TOTAL constant, shared with other cover collectors.
- Sub-module cover_lsb_enc: WIDTH-bit lowest-set-bit encoder (outputs any, index, one-hot mask); reused for clear-one-bit of pend.
- Popcount written as a function in cover_pkg.
- No DPI inside this block; any DIFFTEST shim consumes the out stream.

## Test plan
WIDTH=20, COVER_INDEX=100 unless stated.
- Reset held 3 cycles with valid=all ones -> all outputs 0; first cycle after release with valid=0 -> out_valid=0, covered_count=0.
- valid=0x00005 one cycle, out_ready=1 -> out_index 100 then 102 on consecutive cycles; covered_count=2; valid=0x00005 again -> no output.
- valid=0xFFFFF one cycle, out_ready=0 for 5 cycles then 1 -> out_index 100 held 5 cycles, then 101..119 one per cycle; all_covered=1 after first edge; backlog falls after 119 loaded.
- Stall with out_index=105 pending and pend={110}; valid bit 102 asserted -> after accept, 102 emitted before 110.
- clear pulsed with valid=0x00008 in same cycle after full coverage -> covered_count=1, all_covered=0, index 103 emitted once.
- en=0 with valid=0xFFFFF -> no state change; reset asserted mid-drain -> out_valid=0 next cycle, no further emissions.
